// File: rtl/trig_bus_deframer.sv
// trig_bus_deframer: receive-side deframer for the 320 MHz DDR trigger bus.
// Each lane arrives as an even/odd bit pair per clock; both slots are
// evaluated in order every cycle. Frames are delimited by the enable lane.
// The completed band_phi_id / bcid_extend words are presented with a
// one-cycle valid strobe. Malformed frames raise a one-cycle error strobe
// and bump a saturating counter.
// Optional feature: define TRIG_RX_ODD_ALIGN_EN to accept frames that start
// in the odd slot. Without it, an odd-slot start is a framing error.
module trig_bus_deframer #(
  parameter int FRAME_BITS = 16,
  parameter int ERR_CNT_W  = 16
) (
  input  logic                  clk_320M,
  input  logic                  rst_n,
  input  logic                  en_flag_even,
  input  logic                  en_flag_odd,
  input  logic                  band_phi_id_even,
  input  logic                  band_phi_id_odd,
  input  logic                  bcid_extend_even,
  input  logic                  bcid_extend_odd,
  output logic                  frame_valid,
  output logic [FRAME_BITS-1:0] band_phi_id_word,
  output logic [FRAME_BITS-1:0] bcid_extend_word,
  output logic                  frame_err,
  output logic [ERR_CNT_W-1:0]  err_count
);

  localparam int CNT_W = $clog2(FRAME_BITS + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_BITS);

  typedef enum logic [1:0] {IDLE, RECV, WAIT_LOW} state_t;

  // Registered lanes; bit 0 is the even slot (first in time), bit 1 the odd slot
  logic [1:0] en_q, d1_q, d0_q;

  state_t                state, state_n;
  logic [CNT_W-1:0]      cnt, cnt_n;
  logic                  just_done, just_done_n;
  logic                  prev_done;
  logic [FRAME_BITS-1:0] d1_sr, d1_sr_n, d0_sr, d0_sr_n;
  logic [FRAME_BITS-1:0] cap_d1, cap_d0;
  logic                  done, err;

  logic                  frame_valid_d, frame_err_d;
  logic [FRAME_BITS-1:0] d1_word_d, d0_word_d;
  logic [ERR_CNT_W-1:0]  err_count_d;

`ifdef TRIG_RX_ODD_ALIGN_EN
  logic phase, phase_n;
`endif

  // Register all six lane inputs once before any decoding
  always_ff @(posedge clk_320M) begin
    if (!rst_n) begin
      en_q <= '0;
      d1_q <= '0;
      d0_q <= '0;
    end else begin
      en_q <= {en_flag_odd, en_flag_even};
      d1_q <= {band_phi_id_odd, band_phi_id_even};
      d0_q <= {bcid_extend_odd, bcid_extend_even};
    end
  end

  // FSM state, bit counter, shift registers and the just-completed marker
  always_ff @(posedge clk_320M) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      just_done <= 1'b0;
      d1_sr     <= '0;
      d0_sr     <= '0;
`ifdef TRIG_RX_ODD_ALIGN_EN
      phase     <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      just_done <= just_done_n;
      d1_sr     <= d1_sr_n;
      d0_sr     <= d0_sr_n;
`ifdef TRIG_RX_ODD_ALIGN_EN
      phase     <= phase_n;
`endif
    end
  end

  // Walk the even slot then the odd slot; just_done carries a completion into
  // the very next slot (possibly next cycle) so an enable-high there is an overrun
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    just_done_n = just_done;
    prev_done   = 1'b0;
    d1_sr_n     = d1_sr;
    d0_sr_n     = d0_sr;
    cap_d1      = d1_sr;
    cap_d0      = d0_sr;
    done        = 1'b0;
    err         = 1'b0;
`ifdef TRIG_RX_ODD_ALIGN_EN
    phase_n     = phase;
`endif
    for (int s = 0; s < 2; s++) begin
      prev_done   = just_done_n;
      just_done_n = 1'b0;
      case (state_n)
        IDLE: begin
          if (en_q[s]) begin
            if (prev_done) begin
              err     = 1'b1;
              state_n = WAIT_LOW;
            end
`ifndef TRIG_RX_ODD_ALIGN_EN
            else if (s == 1) begin
              err     = 1'b1;
              state_n = WAIT_LOW;
            end
`endif
            else begin
              cnt_n   = CNT_W'(1);
              d1_sr_n = {d1_sr_n[FRAME_BITS-2:0], d1_q[s]};
              d0_sr_n = {d0_sr_n[FRAME_BITS-2:0], d0_q[s]};
              state_n = RECV;
`ifdef TRIG_RX_ODD_ALIGN_EN
              phase_n = (s == 1);
`endif
            end
          end
        end
        RECV: begin
          if (en_q[s]) begin
            cnt_n   = cnt_n + CNT_W'(1);
            d1_sr_n = {d1_sr_n[FRAME_BITS-2:0], d1_q[s]};
            d0_sr_n = {d0_sr_n[FRAME_BITS-2:0], d0_q[s]};
            if (cnt_n == LAST_CNT) begin
              done        = 1'b1;
              cap_d1      = d1_sr_n;
              cap_d0      = d0_sr_n;
              just_done_n = 1'b1;
              state_n     = IDLE;
            end
          end else begin
            err     = 1'b1;
            state_n = IDLE;
          end
        end
        WAIT_LOW: begin
          if (!en_q[s]) state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Next output values: strobes, held words and the saturating error count
  always_comb begin
    frame_valid_d = done;
    frame_err_d   = err;
    d1_word_d     = done ? cap_d1 : band_phi_id_word;
    d0_word_d     = done ? cap_d0 : bcid_extend_word;
    err_count_d   = err_count;
    if (err && (err_count != '1)) err_count_d = err_count + ERR_CNT_W'(1);
  end

  // Output register giving the second stage of the two-cycle latency
  always_ff @(posedge clk_320M) begin
    if (!rst_n) begin
      frame_valid      <= 1'b0;
      frame_err        <= 1'b0;
      band_phi_id_word <= '0;
      bcid_extend_word <= '0;
      err_count        <= '0;
    end else begin
      frame_valid      <= frame_valid_d;
      frame_err        <= frame_err_d;
      band_phi_id_word <= d1_word_d;
      bcid_extend_word <= d0_word_d;
      err_count        <= err_count_d;
    end
  end

endmodule

// File: tb/tb_trig_bus_deframer.sv
// tb_trig_bus_deframer: directed, table-driven bench for trig_bus_deframer.
// The error counter is built narrow (3 bits) so saturation is reachable.
// Build with TRIG_RX_ODD_ALIGN_EN to check the odd-alignment variant.
module tb_trig_bus_deframer;

  localparam int FB = 16;
  localparam int EW = 3;
  localparam int ERR_MAX = (1 << EW) - 1;

  logic clk_320M = 1'b0;
  logic rst_n;
  logic en_flag_even, en_flag_odd;
  logic band_phi_id_even, band_phi_id_odd;
  logic bcid_extend_even, bcid_extend_odd;
  logic frame_valid, frame_err;
  logic [FB-1:0] band_phi_id_word, bcid_extend_word;
  logic [EW-1:0] err_count;

  trig_bus_deframer #(.FRAME_BITS(FB), .ERR_CNT_W(EW)) dut (
    .clk_320M         (clk_320M),
    .rst_n            (rst_n),
    .en_flag_even     (en_flag_even),
    .en_flag_odd      (en_flag_odd),
    .band_phi_id_even (band_phi_id_even),
    .band_phi_id_odd  (band_phi_id_odd),
    .bcid_extend_even (bcid_extend_even),
    .bcid_extend_odd  (bcid_extend_odd),
    .frame_valid      (frame_valid),
    .band_phi_id_word (band_phi_id_word),
    .bcid_extend_word (bcid_extend_word),
    .frame_err        (frame_err),
    .err_count        (err_count)
  );

  always #5 clk_320M = ~clk_320M;

  int cyc = 0;
  always @(posedge clk_320M) cyc <= cyc + 1;

  // Event log filled on the falling edge, away from the active edge
  int            vcyc[$];
  logic [FB-1:0] vd1[$], vd0[$];
  int            ecyc[$];
  always @(negedge clk_320M) begin
    if (frame_valid) begin
      vcyc.push_back(cyc);
      vd1.push_back(band_phi_id_word);
      vd0.push_back(bcid_extend_word);
    end
    if (frame_err) ecyc.push_back(cyc);
  end

  int checks = 0;
  int passes = 0;
  int exp_err_total = 0;
  logic [FB-1:0] hold_d1 = '0, hold_d0 = '0;

  typedef struct {
    string       name;
    logic [15:0] d1;
    logic [15:0] d0;
    int          lead;
    int          nslots;
    int          exp_valid;
    int          exp_err;
    int          err_slot;
  } vec_t;

  vec_t vecs[6];

  bit slot_en[$], slot_d1[$], slot_d0[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic push_low(input int n);
    for (int i = 0; i < n; i++) begin
      slot_en.push_back(1'b0);
      slot_d1.push_back(1'b0);
      slot_d0.push_back(1'b0);
    end
  endtask

  task automatic push_frame(input logic [15:0] d1, input logic [15:0] d0, input int nslots);
    logic [15:0] s1, s0;
    for (int i = 0; i < nslots; i++) begin
      s1 = d1 << i;
      s0 = d0 << i;
      slot_en.push_back(1'b1);
      slot_d1.push_back(s1[15]);
      slot_d0.push_back(s0[15]);
    end
  endtask

  task automatic drive_cycle(input logic [1:0] en, input logic [1:0] d1, input logic [1:0] d0);
    en_flag_even     = en[0];
    en_flag_odd      = en[1];
    band_phi_id_even = d1[0];
    band_phi_id_odd  = d1[1];
    bcid_extend_even = d0[0];
    bcid_extend_odd  = d0[1];
    @(posedge clk_320M);
    #1;
  endtask

  task automatic clear_log();
    vcyc.delete(); vd1.delete(); vd0.delete(); ecyc.delete();
  endtask

  // Send the queued slots, padded to whole cycles plus idle tail
  task automatic send_slots();
    if (slot_en.size() % 2 != 0) push_low(1);
    push_low(8);
    for (int j = 0; j < slot_en.size(); j += 2)
      drive_cycle({slot_en[j+1], slot_en[j]}, {slot_d1[j+1], slot_d1[j]}, {slot_d0[j+1], slot_d0[j]});
    slot_en.delete(); slot_d1.delete(); slot_d0.delete();
  endtask

  task automatic applyStimulus(input vec_t v, output int start);
    clear_log();
    push_low(v.lead);
    push_frame(v.d1, v.d0, v.nslots);
    start = cyc;
    send_slots();
  endtask

  task automatic checkOutput(input vec_t v, input int start);
    int last;
    last = v.lead + ((v.nslots < FB) ? v.nslots : FB) - 1;
    check({v.name, " valid count"}, vcyc.size(), v.exp_valid);
    if (v.exp_valid == 1 && vcyc.size() == 1) begin
      check({v.name, " valid cycle"}, vcyc[0], start + last / 2 + 2);
      check({v.name, " d1 word"}, vd1[0], v.d1);
      check({v.name, " d0 word"}, vd0[0], v.d0);
      hold_d1 = v.d1;
      hold_d0 = v.d0;
    end
    check({v.name, " err count strobes"}, ecyc.size(), v.exp_err);
    if (v.err_slot >= 0 && ecyc.size() >= 1)
      check({v.name, " err cycle"}, ecyc[0], start + v.err_slot / 2 + 2);
    if (exp_err_total + v.exp_err > ERR_MAX) exp_err_total = ERR_MAX;
    else exp_err_total = exp_err_total + v.exp_err;
    check({v.name, " err_count"}, err_count, exp_err_total);
    check({v.name, " d1 hold"}, band_phi_id_word, hold_d1);
    check({v.name, " d0 hold"}, bcid_extend_word, hold_d0);
  endtask

  initial begin
    int start;
    vec_t sv;

    vecs[0] = '{"even",      16'hA5C3, 16'h1234, 0, 16, 1, 0, -1};
`ifdef TRIG_RX_ODD_ALIGN_EN
    vecs[1] = '{"odd",       16'hA5C3, 16'h1234, 1, 16, 1, 0, -1};
`else
    vecs[1] = '{"odd",       16'hA5C3, 16'h1234, 1, 16, 0, 1, 1};
`endif
    vecs[2] = '{"short",     16'hA5C3, 16'h1234, 0, 10, 0, 1, 10};
    vecs[3] = '{"aftshort",  16'h5A3C, 16'hC0DE, 0, 16, 1, 0, -1};
    vecs[4] = '{"overrun",   16'hA5C3, 16'h1234, 0, 18, 1, 1, -1};
    vecs[5] = '{"aftover",   16'h0F0F, 16'hF00F, 0, 16, 1, 0, -1};

    rst_n = 1'b0;
    en_flag_even = 0; en_flag_odd = 0;
    band_phi_id_even = 0; band_phi_id_odd = 0;
    bcid_extend_even = 0; bcid_extend_odd = 0;
    repeat (3) begin
      @(posedge clk_320M);
      #1;
    end
    check("reset valid", frame_valid, 0);
    check("reset err", frame_err, 0);
    check("reset d1", band_phi_id_word, 0);
    check("reset d0", bcid_extend_word, 0);
    check("reset err_count", err_count, 0);
    rst_n = 1'b1;
    drive_cycle(2'b00, 2'b00, 2'b00);

    for (int k = 0; k < 6; k++) begin
      applyStimulus(vecs[k], start);
      checkOutput(vecs[k], start);
    end

    // Back-to-back frames with the minimum legal gap
    clear_log();
    push_frame(16'hFFFF, 16'h0000, 16);
`ifdef TRIG_RX_ODD_ALIGN_EN
    push_low(1);
`else
    push_low(2);
`endif
    push_frame(16'h0001, 16'h8000, 16);
    start = cyc;
    send_slots();
    check("b2b valid count", vcyc.size(), 2);
    if (vcyc.size() == 2) begin
      check("b2b first cycle", vcyc[0], start + 9);
      check("b2b spacing", vcyc[1] - vcyc[0], 9);
      check("b2b d1 first", vd1[0], 16'hFFFF);
      check("b2b d0 first", vd0[0], 16'h0000);
      check("b2b d1 second", vd1[1], 16'h0001);
      check("b2b d0 second", vd0[1], 16'h8000);
    end
    check("b2b errs", ecyc.size(), 0);
    hold_d1 = 16'h0001;
    hold_d0 = 16'h8000;

    // Drive the error counter into saturation with short frames
    sv = '{"sat", 16'h3C3C, 16'h0FF0, 0, 4, 0, 1, 4};
    for (int k = 0; k < 6; k++) begin
      applyStimulus(sv, start);
      checkOutput(sv, start);
    end
    check("sat final err_count", err_count, ERR_MAX);

    // Reset in the middle of a frame after 6 bits
    clear_log();
    drive_cycle(2'b11, 2'b10, 2'b01);
    drive_cycle(2'b11, 2'b11, 2'b00);
    drive_cycle(2'b11, 2'b01, 2'b10);
    rst_n = 1'b0;
    drive_cycle(2'b00, 2'b00, 2'b00);
    check("midrst valid", frame_valid, 0);
    check("midrst err", frame_err, 0);
    check("midrst d1", band_phi_id_word, 0);
    check("midrst d0", bcid_extend_word, 0);
    check("midrst err_count", err_count, 0);
    rst_n = 1'b1;
    repeat (4) drive_cycle(2'b00, 2'b00, 2'b00);
    check("midrst no err strobe", ecyc.size(), 0);
    check("midrst no valid", vcyc.size(), 0);
    exp_err_total = 0;
    hold_d1 = '0;
    hold_d0 = '0;
    sv = '{"postrst", 16'hBEEF, 16'h7E81, 0, 16, 1, 0, -1};
    applyStimulus(sv, start);
    checkOutput(sv, start);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
